trojan_activity_monitor: RTL and testbench

Runtime detector that sits beside a benchmark core carrying a suspected trigger/payload Trojan. It watches two rare internal nets for coincidence bursts (trigger activity) and compares a protected primary output against a golden recomputed copy (payload activity). It raises a sticky, classified alarm for the Trojan-detection flow.

---
 rtl/trojan_mon_pkg.sv | 14 +
 rtl/coinc_window_counter.sv | 60 ++++++
 rtl/trojan_activity_monitor.sv | 150 +++++++++++++++
 tb/tb_trojan_activity_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/trojan_mon_pkg.sv
// rtl/trojan_mon_pkg.sv - FSM state and alarm cause encodings for trojan_activity_monitor
package trojan_mon_pkg;

    typedef enum logic [1:0] {
        ST_MON   = 2'd0,
        ST_ARMED = 2'd1,
        ST_ALARM = 2'd2
    } mon_state_t;

    localparam logic [1:0] CAUSE_NONE         = 2'b00;
    localparam logic [1:0] CAUSE_PAYLOAD      = 2'b01;
    localparam logic [1:0] CAUSE_TRIG_PAYLOAD = 2'b10;

endpackage

// File: rtl/coinc_window_counter.sv
// rtl/coinc_window_counter.sv - rare-net coincidence edge detector with per-window saturating event count
module coinc_window_counter #(
    parameter int WIN_LEN     = 256,
    parameter int TRIG_THRESH = 3,
    parameter int CNT_W       = 8
) (
    input  logic             CK,
    input  logic             rst,
    input  logic             clr,
    input  logic             probe_a,
    input  logic             probe_b,
    output logic [CNT_W-1:0] ev_count,
    output logic             trig
);

    localparam int WC_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;

    logic [WC_W-1:0]  wc;
    logic             coinc;
    logic             coinc_q;
    logic             ev_pulse;
    logic             wrap;
    logic [CNT_W-1:0] ev_count_next;

    assign coinc    = probe_a & probe_b;
    assign ev_pulse = coinc & ~coinc_q;
    assign wrap     = (wc == WC_W'(WIN_LEN - 1));

    // An event on the wrap cycle belongs to the window that starts next.
    always_comb begin
        ev_count_next = ev_count;
        if (clr) begin
            ev_count_next = '0;
        end else if (wrap) begin
            ev_count_next = CNT_W'(ev_pulse);
        end else if (ev_pulse && (ev_count != {CNT_W{1'b1}})) begin
            ev_count_next = ev_count + CNT_W'(1);
        end
    end

    assign trig = (32'(ev_count_next) >= $unsigned(TRIG_THRESH));

    // coinc_q keeps tracking through clr so a held coincidence is not recounted.
    always_ff @(posedge CK or posedge rst) begin
        if (rst) begin
            coinc_q  <= 1'b0;
            wc       <= '0;
            ev_count <= '0;
        end else begin
            coinc_q  <= coinc;
            ev_count <= ev_count_next;
            if (clr || wrap) begin
                wc <= '0;
            end else begin
                wc <= wc + WC_W'(1);
            end
        end
    end

endmodule

// File: rtl/trojan_activity_monitor.sv
// rtl/trojan_activity_monitor.sv - trigger/payload Trojan detector with sticky classified alarm; TROJAN_MON_LOG_EN adds first_mis_ts
module trojan_activity_monitor
    import trojan_mon_pkg::*;
#(
    parameter int WIN_LEN     = 256,
    parameter int TRIG_THRESH = 3,
    parameter int ARM_TO      = 64,
    parameter int CNT_W       = 8
) (
    input  logic             CK,
    input  logic             rst,
    input  logic             probe_a,
    input  logic             probe_b,
    input  logic             obs_out,
    input  logic             ref_out,
    input  logic             clr,
    output logic             armed,
    output logic             alarm,
    output logic [1:0]       cause,
    output logic             trig_seen,
    output logic [CNT_W-1:0] ev_count,
    output logic [CNT_W-1:0] mis_count
`ifdef TROJAN_MON_LOG_EN
    ,
    output logic [31:0]      first_mis_ts
`endif
);

    localparam int              TMO_W    = (ARM_TO > 1) ? $clog2(ARM_TO + 1) : 1;
    localparam logic [TMO_W-1:0] ARM_LOAD = TMO_W'(ARM_TO - 1);

    mon_state_t       state, state_nxt;
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic [1:0]       cause_nxt;
    logic             seen_nxt;
    logic             trig;
    logic             mis;

    assign mis = obs_out ^ ref_out;

    coinc_window_counter #(
        .WIN_LEN    (WIN_LEN),
        .TRIG_THRESH(TRIG_THRESH),
        .CNT_W      (CNT_W)
    ) u_coinc (
        .CK      (CK),
        .rst     (rst),
        .clr     (clr),
        .probe_a (probe_a),
        .probe_b (probe_b),
        .ev_count(ev_count),
        .trig    (trig)
    );

    // Mismatch outranks trigger; clr outranks both.
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo;
        cause_nxt = cause;
        seen_nxt  = trig_seen;
        if (clr) begin
            state_nxt = ST_MON;
            cause_nxt = CAUSE_NONE;
            seen_nxt  = 1'b0;
        end else begin
            case (state)
                ST_MON: begin
                    if (mis) begin
                        state_nxt = ST_ALARM;
                        cause_nxt = CAUSE_PAYLOAD;
                    end else if (trig) begin
                        state_nxt = ST_ARMED;
                        tmo_nxt   = ARM_LOAD;
                        seen_nxt  = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (mis) begin
                        state_nxt = ST_ALARM;
                        cause_nxt = CAUSE_TRIG_PAYLOAD;
                    end else if (trig) begin
                        tmo_nxt  = ARM_LOAD;
                        seen_nxt = 1'b1;
                    end else if (tmo == '0) begin
                        state_nxt = ST_MON;
                    end else begin
                        tmo_nxt = tmo - TMO_W'(1);
                    end
                end
                ST_ALARM: begin
                    state_nxt = ST_ALARM;
                end
                default: begin
                    state_nxt = ST_MON;
                end
            endcase
        end
    end

    always_ff @(posedge CK or posedge rst) begin
        if (rst) begin
            state     <= ST_MON;
            tmo       <= '0;
            cause     <= CAUSE_NONE;
            trig_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo       <= tmo_nxt;
            cause     <= cause_nxt;
            trig_seen <= seen_nxt;
        end
    end

    assign armed = (state == ST_ARMED);
    assign alarm = (state == ST_ALARM);

    always_ff @(posedge CK or posedge rst) begin
        if (rst) begin
            mis_count <= '0;
        end else if (clr) begin
            mis_count <= '0;
        end else if (mis && (mis_count != {CNT_W{1'b1}})) begin
            mis_count <= mis_count + CNT_W'(1);
        end
    end

`ifdef TROJAN_MON_LOG_EN
    logic [31:0] cyc_cnt;
    logic        mis_logged;

    // The cycle counter survives clr so timestamps stay comparable across clears.
    always_ff @(posedge CK or posedge rst) begin
        if (rst) begin
            cyc_cnt      <= '0;
            first_mis_ts <= '0;
            mis_logged   <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (clr) begin
                first_mis_ts <= '0;
                mis_logged   <= 1'b0;
            end else if (mis && !mis_logged) begin
                first_mis_ts <= cyc_cnt;
                mis_logged   <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trojan_activity_monitor.sv
// tb/tb_trojan_activity_monitor.sv - randomized and directed checks of trojan_activity_monitor against a reference model
module tb_trojan_activity_monitor;

    localparam int WIN_LEN     = 16;
    localparam int TRIG_THRESH = 3;
    localparam int ARM_TO      = 12;
    localparam int CNT_W       = 4;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic             CK = 1'b0;
    logic             rst;
    logic             probe_a, probe_b, obs_out, ref_out, clr;
    logic             armed, alarm, trig_seen;
    logic [1:0]       cause;
    logic [CNT_W-1:0] ev_count, mis_count;
`ifdef TROJAN_MON_LOG_EN
    logic [31:0]      first_mis_ts;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 = watching, 1 = armed, 2 = alarm
    int m_prevc, m_pos, m_ev, m_mode, m_left, m_cause, m_seen, m_mis;

    always #5 CK = ~CK;

    trojan_activity_monitor #(
        .WIN_LEN    (WIN_LEN),
        .TRIG_THRESH(TRIG_THRESH),
        .ARM_TO     (ARM_TO),
        .CNT_W      (CNT_W)
    ) dut (
        .CK       (CK),
        .rst      (rst),
        .probe_a  (probe_a),
        .probe_b  (probe_b),
        .obs_out  (obs_out),
        .ref_out  (ref_out),
        .clr      (clr),
        .armed    (armed),
        .alarm    (alarm),
        .cause    (cause),
        .trig_seen(trig_seen),
        .ev_count (ev_count),
        .mis_count(mis_count)
`ifdef TROJAN_MON_LOG_EN
        ,
        .first_mis_ts(first_mis_ts)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_prevc = 0; m_pos = 0; m_ev = 0; m_mode = 0;
        m_left = 0; m_cause = 0; m_seen = 0; m_mis = 0;
    endtask

    task automatic model_step(input logic a, input logic b, input logic o, input logic r, input logic c);
        int  ev;
        int  nev;
        bit  trig;
        bit  mis;
        ev      = (a && b && m_prevc == 0) ? 1 : 0;
        m_prevc = (a && b) ? 1 : 0;
        mis     = (o != r);
        if (c) begin
            m_ev = 0; m_pos = 0; m_mode = 0; m_cause = 0; m_seen = 0; m_mis = 0;
        end else begin
            if (m_pos == WIN_LEN - 1) nev = ev;
            else nev = (m_ev + ev > SAT) ? SAT : m_ev + ev;
            m_pos = (m_pos + 1) % WIN_LEN;
            m_ev  = nev;
            trig  = (nev >= TRIG_THRESH);
            if (mis && m_mis < SAT) m_mis++;
            if (m_mode == 0) begin
                if (mis) begin m_mode = 2; m_cause = 1; end
                else if (trig) begin m_mode = 1; m_left = ARM_TO - 1; m_seen = 1; end
            end else if (m_mode == 1) begin
                if (mis) begin m_mode = 2; m_cause = 2; end
                else if (trig) m_left = ARM_TO - 1;
                else if (m_left == 0) m_mode = 0;
                else m_left--;
            end
        end
    endtask

    task automatic check_all();
        check("armed",     32'(armed),     32'(m_mode == 1));
        check("alarm",     32'(alarm),     32'(m_mode == 2));
        check("cause",     32'(cause),     32'(m_cause));
        check("trig_seen", 32'(trig_seen), 32'(m_seen));
        check("ev_count",  32'(ev_count),  32'(m_ev));
        check("mis_count", 32'(mis_count), 32'(m_mis));
    endtask

    task automatic cycle(input logic a, input logic b, input logic o, input logic r, input logic c);
        probe_a = a; probe_b = b; obs_out = o; ref_out = r; clr = c;
        @(posedge CK);
        model_step(a, b, o, r, c);
        #1;
        check_all();
    endtask

    task automatic pulses3();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int ev_before;
        rst = 1'b1;
        probe_a = 0; probe_b = 0; obs_out = 0; ref_out = 0; clr = 0;
        model_reset();
        repeat (3) @(posedge CK);
        #1;
        check_all();
        rst = 1'b0;

        // Asynchronous reset mid-window with two events counted
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("ev_before_rst", 32'(ev_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge CK);
        #1 rst = 1'b0;
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("ev_after_rst", 32'(ev_count), 32'd1);

        // Trigger without payload
        cycle(0, 0, 0, 0, 1);
        pulses3();
        check("armed_on_trig", 32'(armed), 32'd1);
        repeat (WIN_LEN + ARM_TO + 4) cycle(0, 0, 0, 0, 0);
        check("armed_timeout", 32'(armed), 32'd0);
        check("seen_sticky", 32'(trig_seen), 32'd1);
        check("no_alarm", 32'(alarm), 32'd0);

        // Trigger then payload
        cycle(0, 0, 0, 0, 1);
        pulses3();
        cycle(0, 0, 1, 0, 0);
        check("tp_alarm", 32'(alarm), 32'd1);
        check("tp_cause", 32'(cause), 32'd2);
        check("tp_mis", 32'(mis_count), 32'd1);
        repeat (500) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0);
        check("tp_sticky", 32'(alarm), 32'd1);

        // Payload only, then saturate mis_count
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        check("p_alarm", 32'(alarm), 32'd1);
        check("p_cause", 32'(cause), 32'd1);
        repeat (SAT + 5) cycle(0, 0, 1, 0, 0);
        check("mis_sat", 32'(mis_count), 32'(SAT));

        // Window wrap: event counted in old window, wrap-cycle event in the new one
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < WIN_LEN; i++) begin
            logic hi;
            hi = (m_pos == WIN_LEN - 3) || (m_pos == WIN_LEN - 1);
            cycle(hi, hi, 0, 0, 0);
        end
        check("wrap_ev", 32'(ev_count), 32'd1);
        cycle(0, 0, 0, 0, 0);
        ev_before = m_ev;
        repeat (10) cycle(1, 1, 0, 0, 0);
        check("held_coinc", 32'(ev_count), 32'(ev_before + 1));

        // clr collides with mismatch and event while in alarm
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 1);
        check("clr_alarm", 32'(alarm), 32'd0);
        check("clr_cause", 32'(cause), 32'd0);
        check("clr_mis", 32'(mis_count), 32'd0);
        check("clr_ev", 32'(ev_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 79) == 0), 1'b0,
                  1'($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
